rx_video_pattern_checker: RTL and testbench



---
 rtl/rx_video_pattern_checker_if.sv | 24 ++
 rtl/rx_video_pattern_checker.sv | 150 +++++++++++++++
 tb/tb_rx_video_pattern_checker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_video_pattern_checker_if.sv
// Deserializer-to-checker link: one clock word plus D lane words per valid beat,
// and the bitslip request travelling back to the deserializer.
interface rx_video_pattern_checker_if #(
   parameter int D = 5
);
   logic           rx_valid;
   logic [6:0]     rx_clk_word;
   logic [7*D-1:0] rx_data;
   logic           bitslip_req;

   modport master (
      output rx_valid,
      output rx_clk_word,
      output rx_data,
      input  bitslip_req
   );

   modport slave (
      input  rx_valid,
      input  rx_clk_word,
      input  rx_data,
      output bitslip_req
   );
endinterface

// File: rtl/rx_video_pattern_checker.sv
// Aligns a 7:1 LVDS receive channel via bitslip and checks the counter pattern.
// Define RXCHK_LANE_ERR_EN to add per-lane sticky error flags on err_lanes.
module rx_video_pattern_checker #(
   parameter int         D            = 5,
   parameter logic [6:0] CLK_PATTERN  = 7'b1100011,
   parameter int         LOCK_COUNT   = 16,
   parameter int         SLIP_HOLDOFF = 4,
   parameter int         ERR_W        = 16
) (
   input  logic                      rx_clk,
   input  logic                      rx_reset_n,
   rx_video_pattern_checker_if.slave rx,
   input  logic                      clear_errors,
   output logic                      rx_locked,
   output logic                      rx_match,
   output logic                      err_sticky,
   output logic [ERR_W-1:0]          err_count,
   output logic [D-1:0]              err_lanes
);

   typedef enum logic [1:0] {
      SEARCH,
      VERIFY,
      LOCKED
   } state_t;

   localparam logic [7:0]       LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [3:0]       HOLD_INIT = 4'(SLIP_HOLDOFF);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t         state;
   logic [3:0]     holdoff;
   logic [7:0]     good_cnt;
   logic [7*D-1:0] ref_q;
   logic           slip_q;

   logic [D-1:0]   lane_bad;
   logic           clk_ok;
   logic           inc_good;
   logic           err_hit;

   // Each lane must advance by exactly one, modulo 128.
   always_comb begin
      lane_bad = '0;
      for (int k = 0; k < D; k++) begin
         logic [6:0] nxt;
         nxt = ref_q[7*k +: 7] + 7'd1;
         lane_bad[k] = rx.rx_data[7*k +: 7] != nxt;
      end
   end

   assign clk_ok   = rx.rx_clk_word == CLK_PATTERN;
   assign inc_good = ~|lane_bad;
   assign err_hit  = rx.rx_valid && state == LOCKED
                   && clk_ok && !inc_good;

   assign rx.bitslip_req = slip_q;

   always_ff @(posedge rx_clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         state     <= SEARCH;
         holdoff   <= '0;
         good_cnt  <= '0;
         ref_q     <= '0;
         slip_q    <= 1'b0;
         rx_locked <= 1'b0;
         rx_match  <= 1'b0;
      end else begin
         slip_q <= 1'b0;
         if (rx.rx_valid) begin
            unique case (state)
               SEARCH: begin
                  if (holdoff != 4'd0) begin
                     holdoff <= holdoff - 4'd1;
                  end else if (!clk_ok) begin
                     slip_q  <= 1'b1;
                     holdoff <= HOLD_INIT;
                  end else begin
                     ref_q    <= rx.rx_data;
                     good_cnt <= '0;
                     state    <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (!clk_ok) begin
                     state <= SEARCH;
                  end else begin
                     ref_q <= rx.rx_data;
                     if (inc_good) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt == LOCK_LAST) begin
                           state     <= LOCKED;
                           rx_locked <= 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end
               end
               LOCKED: begin
                  if (!clk_ok) begin
                     state     <= SEARCH;
                     rx_locked <= 1'b0;
                     rx_match  <= 1'b0;
                  end else begin
                     ref_q    <= rx.rx_data;
                     rx_match <= inc_good;
                  end
               end
               default: begin
                  state     <= SEARCH;
                  rx_locked <= 1'b0;
                  rx_match  <= 1'b0;
               end
            endcase
         end
      end
   end

   // A clear in the same cycle as an error wins, leaving the count at zero.
   always_ff @(posedge rx_clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else if (clear_errors) begin
         err_count  <= '0;
         err_sticky <= 1'b0;
      end else if (err_hit) begin
         err_sticky <= 1'b1;
         if (err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

`ifdef RXCHK_LANE_ERR_EN
   always_ff @(posedge rx_clk or negedge rx_reset_n) begin
      if (!rx_reset_n) begin
         err_lanes <= '0;
      end else if (clear_errors) begin
         err_lanes <= '0;
      end else if (err_hit) begin
         err_lanes <= err_lanes | lane_bad;
      end
   end
`else
   assign err_lanes = '0;
`endif

endmodule

// File: tb/tb_rx_video_pattern_checker.sv
// Directed bench for rx_video_pattern_checker: lock, wrap, errors, clear,
// clock-word loss, async reset and bitslip alignment.
module tb_rx_video_pattern_checker;

   localparam int         D   = 5;
   localparam logic [6:0] CLK = 7'b1100011;

`ifdef RXCHK_LANE_ERR_EN
   localparam logic [4:0] EXP_LANE2 = 5'b00100;
`else
   localparam logic [4:0] EXP_LANE2 = 5'b00000;
`endif

   logic        rx_clk;
   logic        rx_reset_n;
   logic        clear_errors;
   logic        rx_locked;
   logic        rx_match;
   logic        err_sticky;
   logic [15:0] err_count;
   logic [4:0]  err_lanes;

   rx_video_pattern_checker_if #(.D(D)) rx ();

   rx_video_pattern_checker #(
      .D(D),
      .CLK_PATTERN(CLK),
      .LOCK_COUNT(16),
      .SLIP_HOLDOFF(4),
      .ERR_W(16)
   ) dut (
      .rx_clk      (rx_clk),
      .rx_reset_n  (rx_reset_n),
      .rx          (rx),
      .clear_errors(clear_errors),
      .rx_locked   (rx_locked),
      .rx_match    (rx_match),
      .err_sticky  (err_sticky),
      .err_count   (err_count),
      .err_lanes   (err_lanes)
   );

   initial rx_clk = 1'b0;
   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic        v;
      logic [6:0]  cw;
      logic [34:0] d;
      logic        e_lock;
      logic        e_match;
      logic        e_slip;
      logic [15:0] e_cnt;
      logic        e_sticky;
   } vec_t;

   vec_t tbl [24];
   int   n_cmp = 0;
   int   n_err = 0;
   int   off [5];
   int   n;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [34:0] pack(input int idx);
      logic [34:0] w;
      w = '0;
      for (int k = 0; k < D; k++)
         w[7*k +: 7] = 7'((k + 1 + idx + off[k]) & 127);
      return w;
   endfunction

   function automatic logic [6:0] rotl(input logic [6:0] x, input int r);
      logic [6:0] y;
      for (int i = 0; i < 7; i++) y[(i + r) % 7] = x[i];
      return y;
   endfunction

   task automatic send(input logic v, input logic [6:0] cw,
                       input logic [34:0] d, input logic clr);
      @(negedge rx_clk);
      rx.rx_valid    = v;
      rx.rx_clk_word = cw;
      rx.rx_data     = d;
      clear_errors   = clr;
      @(posedge rx_clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_lock"}, 32'(rx_locked), 0);
      chk({tag, "_match"}, 32'(rx_match), 0);
      chk({tag, "_sticky"}, 32'(err_sticky), 0);
      chk({tag, "_cnt"}, 32'(err_count), 0);
      chk({tag, "_lanes"}, 32'(err_lanes), 0);
      chk({tag, "_slip"}, 32'(rx.bitslip_req), 0);
   endtask

   initial begin
      int slips;
      int gap;
      int rot;
      int iter;

      for (int k = 0; k < D; k++) off[k] = 0;
      rx_reset_n     = 1'b0;
      rx.rx_valid    = 1'b0;
      rx.rx_clk_word = '0;
      rx.rx_data     = '0;
      clear_errors   = 1'b0;

      n = 0;
      for (int i = 0; i < 24; i++) begin
         tbl[i].e_slip   = 1'b0;
         tbl[i].e_cnt    = '0;
         tbl[i].e_sticky = 1'b0;
         if (i == 20) begin
            tbl[i].v       = 1'b0;
            tbl[i].cw      = 7'h00;
            tbl[i].d       = '1;
            tbl[i].e_lock  = 1'b1;
            tbl[i].e_match = 1'b1;
         end else begin
            tbl[i].v       = 1'b1;
            tbl[i].cw      = CLK;
            tbl[i].d       = pack(n);
            tbl[i].e_lock  = n >= 16;
            tbl[i].e_match = n >= 17;
            n++;
         end
      end

      repeat (3) @(posedge rx_clk);
      #1;
      chk_zero("reset");
      @(negedge rx_clk);
      rx_reset_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         send(tbl[i].v, tbl[i].cw, tbl[i].d, 1'b0);
         chk($sformatf("tbl%0d_lock", i), 32'(rx_locked), 32'(tbl[i].e_lock));
         chk($sformatf("tbl%0d_match", i), 32'(rx_match), 32'(tbl[i].e_match));
         chk($sformatf("tbl%0d_slip", i), 32'(rx.bitslip_req), 32'(tbl[i].e_slip));
         chk($sformatf("tbl%0d_cnt", i), 32'(err_count), 32'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d_sticky", i), 32'(err_sticky), 32'(tbl[i].e_sticky));
      end

      // Stream through the 7F -> 00 wrap on every lane.
      while (n < 132) begin
         send(1'b1, CLK, pack(n), 1'b0);
         if (n >= 125 && n <= 127) begin
            chk($sformatf("wrap%0d_match", n), 32'(rx_match), 1);
            chk($sformatf("wrap%0d_cnt", n), 32'(err_count), 0);
         end else if (rx_match !== 1'b1) begin
            chk($sformatf("stream%0d_match", n), 32'(rx_match), 1);
         end
         n++;
      end

      off[2] = off[2] + 1;
      send(1'b1, CLK, pack(n), 1'b0);
      n++;
      chk("inj_match", 32'(rx_match), 0);
      chk("inj_cnt", 32'(err_count), 1);
      chk("inj_sticky", 32'(err_sticky), 1);
      chk("inj_lanes", 32'(err_lanes), 32'(EXP_LANE2));
      chk("inj_lock", 32'(rx_locked), 1);
      send(1'b1, CLK, pack(n), 1'b0);
      n++;
      chk("inj_next_match", 32'(rx_match), 1);
      chk("inj_next_cnt", 32'(err_count), 1);

      send(1'b1, CLK ^ 7'h01, pack(n), 1'b0);
      n++;
      chk("cwloss_lock", 32'(rx_locked), 0);
      chk("cwloss_match", 32'(rx_match), 0);
      chk("cwloss_cnt", 32'(err_count), 1);
      chk("cwloss_slip", 32'(rx.bitslip_req), 0);

      for (int i = 0; i < 5; i++) begin
         send(1'b1, CLK, pack(n), 1'b0);
         n++;
      end
      chk("verify_lock", 32'(rx_locked), 0);
      chk("verify_slip", 32'(rx.bitslip_req), 0);

      @(negedge rx_clk);
      rx.rx_valid    = 1'b1;
      rx.rx_clk_word = CLK;
      rx.rx_data     = pack(n);
      #2;
      rx_reset_n = 1'b0;
      #1;
      chk_zero("areset");
      @(posedge rx_clk);
      #1;
      chk_zero("areset_hold");
      @(negedge rx_clk);
      rx_reset_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         send(1'b1, CLK, pack(n), 1'b0);
         n++;
      end
      chk("relock15_lock", 32'(rx_locked), 0);
      send(1'b1, CLK, pack(n), 1'b0);
      n++;
      chk("relock16_lock", 32'(rx_locked), 1);

      off[1] = off[1] + 1;
      send(1'b1, CLK, pack(n), 1'b0);
      n++;
      chk("preclr_cnt", 32'(err_count), 1);
      off[1] = off[1] + 1;
      send(1'b1, CLK, pack(n), 1'b1);
      n++;
      chk("clr_cnt", 32'(err_count), 0);
      chk("clr_sticky", 32'(err_sticky), 0);
      chk("clr_lanes", 32'(err_lanes), 0);
      chk("clr_match", 32'(rx_match), 0);
      send(1'b1, CLK, pack(n), 1'b0);
      n++;
      chk("postclr_match", 32'(rx_match), 1);
      chk("postclr_cnt", 32'(err_count), 0);

      send(1'b1, 7'h00, pack(n), 1'b0);
      n++;
      chk("mis_enter_lock", 32'(rx_locked), 0);
      rot   = 3;
      slips = 0;
      gap   = 0;
      iter  = 0;
      while (rx_locked !== 1'b1 && iter < 200) begin
         send(1'b1, rotl(CLK, rot), pack(n), 1'b0);
         n++;
         iter++;
         if (rx.bitslip_req === 1'b1) begin
            if (slips > 0) chk("slip_gap_ok", 32'(gap >= 4), 1);
            slips++;
            gap = 0;
            if (rot > 0) rot--;
         end else begin
            gap++;
         end
      end
      if (iter >= 200) chk("mis_timeout", 32'(iter), 0);
      chk("mis_slips", 32'(slips), 3);
      chk("mis_lock", 32'(rx_locked), 1);
      chk("mis_cnt", 32'(err_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
